// File: rtl/tank_pkg.sv
// Shared constants and types for tank sprite renderers.
//   SPR_W/SPR_H   : sprite box size in pixels
//   ROW_BITS      : sprite ROM row width, 2 bits per pixel
//   ADDR_W        : sprite ROM address width
//   color_idx_t   : 2-bit palette index, 0 is transparent
//   dir_t         : tank facing direction
//   dir_to_flip() : facing direction -> vertical/horizontal mirror flags
package tank_pkg;

  localparam int SPR_W    = 13;
  localparam int SPR_H    = 16;
  localparam int ROW_BITS = 26;
  localparam int ADDR_W   = 11;

  typedef logic [1:0] color_idx_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic flip_v;
    logic flip_h;
  } flip_t;

  // The sprite art faces up/right; down and left are produced by mirroring.
  function automatic flip_t dir_to_flip(input dir_t dir);
    flip_t f;
    f = '0;
    case (dir)
      DOWN:    f.flip_v = 1'b1;
      LEFT:    f.flip_h = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Tread / sprite animation frame selector.
//   Clk, Reset_n  : pixel clock, asynchronous active-low reset
//   frame_start   : one-cycle pulse per video frame
//   moving        : animate this frame (already latched by the caller)
//   anim_frame    : selected sprite frame, toggles every ANIM_FRAMES frames
module sprite_anim_ctr #(
  parameter int ANIM_FRAMES = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_start,
  input  logic moving,
  output logic anim_frame
);

  localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt        <= '0;
      anim_frame <= 1'b0;
    end else if (frame_start && moving) begin
      if (cnt == CNT_LAST) begin
        cnt        <= '0;
        anim_frame <= ~anim_frame;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/playertank_draw.sv
// Player tank sprite renderer, one pixel per clock, fixed 2-cycle latency.
//   Clk, Reset_n            : pixel clock, asynchronous active-low reset
//   frame_start             : vertical-blank pulse; latches TankX/TankY/flips/moving
//   DrawX, DrawY            : scan position of the pixel being presented
//   TankX, TankY            : tank top-left corner
//   flip_v, flip_h, moving  : facing mirrors and tread animation enable
//   rom_addr                : registered row address to the sprite ROM
//   rom_data                : ROM row returned combinationally for rom_addr
//   pixel_on, color_idx     : opaque-pixel flag and palette index (0 when off)
module playertank_draw
  import tank_pkg::*;
#(
  parameter int SPR_BASE    = 0,
  parameter int ANIM_FRAMES = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_start,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic [9:0]          TankX,
  input  logic [9:0]          TankY,
  input  logic                flip_v,
  input  logic                flip_h,
  input  logic                moving,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [ROW_BITS-1:0] rom_data,
  output logic                pixel_on,
  output color_idx_t          color_idx
);

  localparam int ROW_IW = $clog2(SPR_H);
  localparam int COL_IW = $clog2(SPR_W);

  // Column 0 is the MSB pair of the row; columns past SPR_W read as transparent.
  function automatic color_idx_t slice_pix(input logic [ROW_BITS-1:0] row_bits,
                                           input logic [COL_IW-1:0]   col);
    color_idx_t p;
    p = '0;
    for (int i = 0; i < SPR_W; i++) begin
      if (col == COL_IW'(i)) p = row_bits[ROW_BITS-1-2*i -: 2];
    end
    return p;
  endfunction

  logic [9:0] tx_q, ty_q;
  logic       flip_v_q, flip_h_q, moving_q;
  logic       anim_frame;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_q     <= '0;
      ty_q     <= '0;
      flip_v_q <= 1'b0;
      flip_h_q <= 1'b0;
      moving_q <= 1'b0;
    end else if (frame_start) begin
      tx_q     <= TankX;
      ty_q     <= TankY;
      flip_v_q <= flip_v;
      flip_h_q <= flip_h;
      moving_q <= moving;
    end
  end

  // Counter sees the moving flag latched for the frame that is ending.
  sprite_anim_ctr #(
    .ANIM_FRAMES (ANIM_FRAMES)
  ) u_anim (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .moving      (moving_q),
    .anim_frame  (anim_frame)
  );

  // ---- stage 0: box test and row/column index (combinational) ----
  logic [10:0]             x_lo_p0, x_hi_p0, y_lo_p0, y_hi_p0;
  logic                    in_box_p0;
  logic [ROW_IW-1:0]       row_off_p0, row_p0;
  logic [COL_IW-1:0]       col_off_p0, col_p0;
  logic [ADDR_W-1:0]       addr_p0;

  // 11-bit bounds so a tank at the right/bottom edge never wraps to 0.
  assign x_lo_p0   = {1'b0, tx_q};
  assign x_hi_p0   = {1'b0, tx_q} + 11'(SPR_W);
  assign y_lo_p0   = {1'b0, ty_q};
  assign y_hi_p0   = {1'b0, ty_q} + 11'(SPR_H);
  assign in_box_p0 = ({1'b0, DrawX} >= x_lo_p0) && ({1'b0, DrawX} < x_hi_p0) &&
                     ({1'b0, DrawY} >= y_lo_p0) && ({1'b0, DrawY} < y_hi_p0);

  // Offsets are only meaningful inside the box, where the low bits suffice.
  assign row_off_p0 = DrawY[ROW_IW-1:0] - ty_q[ROW_IW-1:0];
  assign col_off_p0 = DrawX[COL_IW-1:0] - tx_q[COL_IW-1:0];
  assign row_p0     = flip_v_q ? ROW_IW'(SPR_H - 1) - row_off_p0 : row_off_p0;
  assign col_p0     = flip_h_q ? COL_IW'(SPR_W - 1) - col_off_p0 : col_off_p0;
  assign addr_p0    = ADDR_W'(SPR_BASE) + (anim_frame ? ADDR_W'(SPR_H) : '0) +
                      ADDR_W'(row_p0);

  // ---- stage 1: ROM address issued, box flag and column carried along ----
  logic              in_box_p1;
  logic [COL_IW-1:0] col_p1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      in_box_p1 <= 1'b0;
      col_p1    <= '0;
    end else begin
      in_box_p1 <= in_box_p0;
      col_p1    <= col_p0;
      if (in_box_p0) rom_addr <= addr_p0;
    end
  end

  // ---- stage 2: slice ROM row, apply transparency ----
  color_idx_t pix_p1;
  logic       pixel_on_next;

  assign pix_p1        = slice_pix(rom_data, col_p1);
  assign pixel_on_next = in_box_p1 && (pix_p1 != 2'd0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_on  <= 1'b0;
      color_idx <= '0;
    end else begin
      pixel_on  <= pixel_on_next;
      color_idx <= pixel_on_next ? pix_p1 : 2'd0;
    end
  end

endmodule

// File: tb/tb_playertank_draw.sv
module tb_playertank_draw;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, TankX = '0, TankY = '0;
  logic        flip_v = 1'b0, flip_h = 1'b0, moving = 1'b0;
  logic [10:0] rom_addr;
  logic [25:0] rom_data;
  logic        pixel_on;
  logic [1:0]  color_idx;

  logic [25:0] rom [0:2047];
  assign rom_data = rom[rom_addr];

  always #5 Clk = ~Clk;

  playertank_draw dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .TankX       (TankX),
    .TankY       (TankY),
    .flip_v      (flip_v),
    .flip_h      (flip_h),
    .moving      (moving),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_on    (pixel_on),
    .color_idx   (color_idx)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the tank looks like this frame
  int m_tx, m_ty, m_fv, m_fh, m_mv, m_cnt, m_frame;
  int m_addr;        // last address driven to the ROM
  int d_on, d_col;   // pixel result waiting to appear at the outputs

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sprite geometry from the drawing rules, in plain integer arithmetic
  task automatic model_pix(input int dx, input int dy,
                           output bit inb, output int addr, output int color);
    int row, col;
    inb = (dx >= m_tx) && (dx < m_tx + 13) && (dy >= m_ty) && (dy < m_ty + 16);
    row = dy - m_ty;
    col = dx - m_tx;
    if (m_fv != 0) row = 15 - row;
    if (m_fh != 0) col = 12 - col;
    addr  = 0;
    color = 0;
    if (inb) begin
      addr  = m_frame * 16 + row;
      color = int'((rom[addr] >> (24 - 2 * col)) & 26'd3);
    end
  endtask

  task automatic model_reset();
    m_tx = 0; m_ty = 0; m_fv = 0; m_fh = 0; m_mv = 0; m_cnt = 0; m_frame = 0;
    m_addr = 0; d_on = 0; d_col = 0;
  endtask

  // One pixel clock: present a pixel, advance, compare against the model
  task automatic cycle(input bit fs, input int dx, input int dy);
    bit inb;
    int a, c;
    frame_start = fs;
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    model_pix(dx & 1023, dy & 1023, inb, a, c);
    if (inb) m_addr = a;
    if (fs) begin
      if (m_mv != 0) begin
        m_cnt++;
        if (m_cnt == 4) begin
          m_cnt = 0;
          m_frame = 1 - m_frame;
        end
      end
      m_tx = int'(TankX); m_ty = int'(TankY);
      m_fv = int'(flip_v); m_fh = int'(flip_h); m_mv = int'(moving);
    end
    @(posedge Clk);
    #1;
    chk("rom_addr", int'(rom_addr), m_addr);
    chk("pixel_on", int'(pixel_on), d_on);
    chk("color_idx", int'(color_idx), d_col);
    d_on  = (inb && c != 0) ? 1 : 0;
    d_col = inb ? c : 0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_pixel_on", int'(pixel_on), 0);
    chk("rst_color_idx", int'(color_idx), 0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic latch(input int tx, input int ty, input bit fv, input bit fh, input bit mv);
    TankX = 10'(tx); TankY = 10'(ty); flip_v = fv; flip_h = fh; moving = mv;
    cycle(1'b1, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 26'($urandom);
    rom[0] = 26'b00000000000001000000000000;
    rom[4] = 26'b10111100001101110000101111;
    rom[7] = 26'h3FFFFFF;
    model_reset();

    do_reset();

    // Plain placement, colour 1 at column 6 of row 0
    latch(100, 50, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 106, 50);
    chk("tp1_addr", int'(rom_addr), 0);
    cycle(1'b0, 100, 54);
    chk("tp1_on", int'(pixel_on), 1);
    chk("tp1_color", int'(color_idx), 1);
    chk("tp2_addr", int'(rom_addr), 4);
    cycle(1'b0, 0, 0);
    chk("tp2_color", int'(color_idx), 2);

    // Vertical flip: top scan row reads the last sprite row
    latch(100, 50, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 100, 50);
    chk("flipv_addr", int'(rom_addr), 15);
    // Horizontal flip: leftmost screen column reads sprite column 12
    latch(100, 50, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 100, 54);
    cycle(1'b0, 0, 0);
    chk("fliph_color", int'(color_idx), 3);

    // Right screen edge
    latch(1015, 100, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1014, 107);
    cycle(1'b0, 1023, 107);
    chk("edge_left_out", int'(pixel_on), 0);
    chk("edge_in_addr", int'(rom_addr), 7);
    cycle(1'b0, 1023, 116);
    chk("edge_in_on", int'(pixel_on), 1);
    chk("edge_in_color", int'(color_idx), 3);
    cycle(1'b0, 0, 0);
    chk("edge_below_out", int'(pixel_on), 0);

    // Tread animation while moving, then hold
    latch(200, 100, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1, 0, 0);
      cycle(1'b0, 200, 100);
      chk("anim_addr", int'(rom_addr), ((k / 4) % 2) * 16);
    end
    moving = 1'b0;
    cycle(1'b1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 0, 0);
      cycle(1'b0, 200, 100);
      chk("hold_addr", int'(rom_addr), 16);
    end

    // Randomized traffic with a reset in the middle of a line
    for (int i = 0; i < 3000; i++) begin
      bit fs;
      int dx, dy;
      if (i == 1500) begin
        do_reset();
        TankX = 10'd500; TankY = 10'd300;
        cycle(1'b0, 5, 3);
      end
      fs = ($urandom_range(0, 39) == 0);
      if (fs) begin
        TankX  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1005, 1023))
                                             : 10'($urandom_range(0, 1023));
        TankY  = 10'($urandom_range(0, 1023));
        flip_v = 1'($urandom_range(0, 1));
        flip_h = 1'($urandom_range(0, 1));
        moving = ($urandom_range(0, 3) != 0);
      end
      dx = m_tx + int'($urandom_range(0, 19)) - 3;
      dy = m_ty + int'($urandom_range(0, 22)) - 3;
      cycle(fs, dx, dy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
